gtb_seq_decoder: RTL

//  Downstream stage of the binary-to-Gray encoder: consumes one Gray-coded word
//  per handshake and reconstructs binary bit-serially, MSB first, one bit per clock.

---
 rtl/gtb_seq_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gtb_seq_decoder.sv
// Bit-serial Gray-to-binary decoder, MSB first, one bit per clock, valid/ready on both sides.
// Optional step checker enabled by defining GTB_STEP_CHECK_EN.
module gtb_seq_decoder #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_gray,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_bin,
   output logic         step_err,
   output logic [1:0]   o_state
);

   // Handshake: a word moves on a rising edge where valid && ready are both high;
   // valid never depends combinationally on ready, and a held word stays stable until taken.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int CW = (W > 2) ? $clog2(W - 1) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_greg;
   logic [W-1:0]    r_bin;
   logic [W-1:0]    w_bin_shift;
   logic [CW-1:0]   r_cnt;
   logic            w_accept;
   logic            w_release;

   assign w_accept  = in_valid & in_ready;
   assign w_release = (r_state == ST_HOLD) & out_ready;
   assign out_bin   = r_bin;
   assign o_state   = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (r_cnt == '0) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Resolve the bit selected by r_cnt from its already-decoded upper neighbour.
   always_comb begin
      w_bin_shift        = r_bin;
      w_bin_shift[W-1]   = r_greg[W-1];
      for (int i = 0; i < W - 1; i++) begin
         if (CW'(i) == r_cnt) w_bin_shift[i] = r_bin[i+1] ^ r_greg[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_greg <= '0;
         r_bin  <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_greg <= in_gray;
         r_bin  <= {in_gray[W-1], {(W-1){1'b0}}};
         r_cnt  <= CW'(W - 2);
      end else if (r_state == ST_SHIFT) begin
         r_bin <= w_bin_shift;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

`ifdef GTB_STEP_CHECK_EN
   localparam int PW = $clog2(W + 1);

   logic [W-1:0]  r_prev;
   logic          r_prev_vld;
   logic          r_step_err;
   logic [PW-1:0] w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < W; i++) begin
         w_pop = w_pop + PW'(in_gray[i] ^ r_prev[i]);
      end
   end

   // prev tracks the last word delivered downstream, not merely accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
         r_step_err <= 1'b0;
      end else begin
         if (w_release) begin
            r_prev     <= r_greg;
            r_prev_vld <= 1'b1;
         end
         if (w_accept) r_step_err <= r_prev_vld && (w_pop > PW'(1));
      end
   end

   assign step_err = r_step_err;
`else
   assign step_err = 1'b0;
`endif

endmodule
